// File: rtl/sr_deser.sv
// sr_deser: start-framed serial-to-parallel deserializer with selectable bit order and a handshaked output word.
// Define SR_DESER_PARITY_EN to append one even-parity bit to every frame and report it on parity_err.
module sr_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             incr,
    input  logic             en,
    input  logic             sdi,
    input  logic             ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [IW:0]   CNT_ONE = (IW+1)'(1);
`ifdef SR_DESER_PARITY_EN
    // The frame ends on the parity bit that follows the last data bit.
    localparam logic [IW:0]   CNT_LAST = (IW+1)'(WIDTH);
`else
    localparam logic [IW:0]   CNT_LAST = (IW+1)'(WIDTH - 1);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    idx;
    logic             dir;
    logic [IW:0]      count;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_ins;
    logic             bit_stb;
    logic             data_bit;
    logic             complete;

    // A start always wins over the bit strobe, including the completing one.
    assign bit_stb  = (state == RECV) && en && !start;
    assign complete = bit_stb && (count == CNT_LAST);
`ifdef SR_DESER_PARITY_EN
    assign data_bit = bit_stb && (count != CNT_LAST);
`else
    assign data_bit = bit_stb;
`endif

    always_comb begin
        shadow_ins      = shadow;
        shadow_ins[idx] = sdi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RECV;
        end else if (complete) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy = (state == RECV);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx    <= '0;
            dir    <= 1'b0;
            count  <= '0;
            shadow <= '0;
        end else if (start) begin
            idx    <= incr ? '0 : IDX_TOP;
            dir    <= incr;
            count  <= '0;
            shadow <= '0;
        end else if (data_bit) begin
            shadow <= shadow_ins;
            idx    <= dir ? (idx + IDX_ONE) : (idx - IDX_ONE);
            count  <= count + CNT_ONE;
        end
    end

    // Output word handshake: a completion always wins over an ack in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
`ifdef SR_DESER_PARITY_EN
            dout       <= shadow;
`else
            dout       <= shadow_ins;
`endif
            dout_valid <= 1'b1;
            if (dout_valid && !ack) begin
                overrun <= 1'b1;
            end
        end else if (ack) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef SR_DESER_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err <= 1'b0;
        end else if (complete) begin
            parity_err <= (^shadow) ^ sdi;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_deser.sv
// Bench for sr_deser: directed and randomized frames checked against a scoreboard of model words.
// Build with SR_DESER_PARITY_EN defined to exercise the parity-bit variant.
module tb_sr_deser;

    localparam int W = 8;
`ifdef SR_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NPRE = PAR ? W : W - 1;

    typedef struct packed {
        logic [W-1:0] d;
        logic         p;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   m_run = 0;
    int   m_fail = 0;

    logic         clk = 1'b0;
    logic         reset_n, start, incr, en, sdi, ack;
    logic         ack_dir, ack_mon, mon_ack;
    logic [W-1:0] dout;
    logic         dout_valid, busy, overrun, parity_err;
    logic         prev_busy = 1'b0;
    exp_t         me;

    assign ack = ack_dir | ack_mon;

    always #5 clk = ~clk;

    sr_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .incr       (incr),
        .en         (en),
        .sdi        (sdi),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Monitor: a completed frame shows up as busy dropping while out of reset.
    initial ack_mon = 1'b0;
    always @(posedge clk) begin
        #1;
        ack_mon = 1'b0;
        if (reset_n && prev_busy && !busy) begin
            m_run++;
            if (sb.size() == 0) begin
                m_fail++;
                $display("FAIL unexpected_word: dout=%h appeared with no word expected", dout);
            end else begin
                me = sb.pop_front();
                if (dout !== me.d || dout_valid !== 1'b1 || overrun !== me.o || parity_err !== me.p) begin
                    m_fail++;
                    $display("FAIL word: got dout=%h vld=%b ovr=%b perr=%b, expected dout=%h vld=1 ovr=%b perr=%b",
                             dout, dout_valid, overrun, parity_err, me.d, me.o, me.p);
                end
            end
            if (mon_ack) ack_mon = 1'b1;
        end
        prev_busy = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) @(negedge clk);
        en  = 1'b1;
        sdi = b;
        @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic do_start(input logic inc);
        start = 1'b1;
        incr  = inc;
        en    = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // seq[k] is the k-th bit on the wire; the model places it by bit order.
    task automatic run_frame(input logic inc, input logic [W-1:0] seq, input int gap,
                             input logic pb, input logic ovr, input logic st);
        exp_t e;
        int   w = 0;
        for (int k = 0; k < W; k++)
            if (seq[k]) w = w + (1 << (inc ? k : W - 1 - k));
        e.d = w[W-1:0];
        e.o = ovr;
        e.p = PAR & ((^seq) ^ pb);
        sb.push_back(e);
        if (st) do_start(inc);
        for (int k = 0; k < W; k++) send_bit(seq[k], gap);
`ifdef SR_DESER_PARITY_EN
        chk("par_wait_busy", 32'(busy), 32'd1);
        chk("par_wait_vld", 32'(dout_valid), 32'(ovr));
        send_bit(pb, gap);
`endif
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; incr = 1'b0; en = 1'b0; sdi = 1'b0;
        ack_dir = 1'b0; mon_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_vld", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // bits 1,0,1,1,0,0,1,0 on the wire
        run_frame(1'b1, 8'h4D, 0, 1'b1, 1'b0, 1'b1);
        chk("lsb_dout", 32'(dout), 32'h4D);
        chk("lsb_vld", 32'(dout_valid), 32'd1);
        chk("lsb_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        run_frame(1'b0, 8'h4D, 0, 1'b0, 1'b0, 1'b1);
        chk("msb_dout", 32'(dout), 32'hB2);
        repeat (2) @(negedge clk);

        // aborted partial frames leave no trace
        do_start(1'b1);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 0);
        run_frame(1'b1, 8'hF0, 0, 1'b0, 1'b0, 1'b1);
        chk("abort_dout", 32'(dout), 32'hF0);
        do_start(1'b0);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 3);
        run_frame(1'b1, 8'hF0, 3, 1'b1, 1'b0, 1'b1);
        chk("abort_gap_dout", 32'(dout), 32'hF0);

        // start coinciding with the completing strobe restarts instead of completing
        do_start(1'b1);
        for (int k = 0; k < NPRE; k++) send_bit(1'b1, 0);
        en = 1'b1; sdi = 1'b1; start = 1'b1; incr = 1'b0;
        @(negedge clk);
        en = 1'b0; start = 1'b0;
        chk("start_prio_busy", 32'(busy), 32'd1);
        run_frame(1'b0, 8'h3A, 1, 1'b1, 1'b0, 1'b0);
        chk("start_prio_dout", 32'(dout), 32'h5C);

        // parity result: 8'h07 has odd weight
        repeat (2) @(negedge clk);
        run_frame(1'b1, 8'h07, 0, 1'b1, 1'b0, 1'b1);
        chk("perr_good", 32'(parity_err), 32'd0);
        repeat (2) @(negedge clk);
        run_frame(1'b1, 8'h07, 0, 1'b0, 1'b0, 1'b1);
        chk("perr_bad", 32'(parity_err), 32'(PAR));

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_start(1'($urandom));
                for (int k = 0; k < $urandom_range(1, W - 1); k++) send_bit(1'($urandom), 0);
            end
            run_frame(1'($urandom), W'($urandom), $urandom_range(0, 2), 1'($urandom), 1'b0, 1'b1);
        end

        // overrun: two words without ack
        repeat (3) @(negedge clk);
        mon_ack = 1'b0;
        run_frame(1'b1, 8'hA5, 0, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 8'h3C, 0, 1'b0, 1'b1, 1'b1);
        chk("ovr_dout", 32'(dout), 32'h3C);
        chk("ovr_vld", 32'(dout_valid), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        ack_dir = 1'b1;
        @(negedge clk);
        ack_dir = 1'b0;
        chk("ovr_ack_vld", 32'(dout_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        mon_ack = 1'b1;

        // reset mid-frame, then strobes without start
        do_start(1'b1);
        for (int k = 0; k < 5; k++) send_bit(1'b1, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_vld", 32'(dout_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_perr", 32'(parity_err), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < W + 1; k++) send_bit(1'b1, 0);
        chk("post_rst_vld", 32'(dout_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_dout", 32'(dout), 32'd0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run + m_run, n_fail + m_fail);
        $finish;
    end

endmodule

// File: doc/sr_deser.md
SR_DESER -- requirements
Module: sr_deser

Interface
REQ-001 Parameter: WIDTH, 8, frame data bit count; SHALL be a power of two in 2..32; index width IW = clog2(WIDTH).
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge, except on reset.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  frame start strobe.
REQ-005 incr  input  1  bit order, sampled on start: 1 = index 0 upward (LSB first), 0 = index WIDTH-1 downward (MSB first).
REQ-006 en  input  1  bit strobe; sdi is captured on cycles with en=1.
REQ-007 sdi  input  1  serial data in.
REQ-008 ack  input  1  consumer acknowledge of dout.
REQ-009 dout  output  WIDTH  last completed word, registered.
REQ-010 dout_valid  output  1  dout holds an unacknowledged word.
REQ-011 busy  output  1  high in state RECV.
REQ-012 overrun  output  1  sticky: a word was lost.
REQ-013 parity_err  output  1  parity result of the word in dout (see Configuration).

Function
REQ-014 FSM states: IDLE, RECV; busy SHALL equal (state==RECV).
REQ-015 On start, from any state: go to RECV, idx <= incr ? 0 : WIDTH-1, dir <= incr, bit count <= 0, shadow register cleared; any partial frame is discarded.
REQ-016 In IDLE, en and sdi SHALL be ignored.
REQ-017 In RECV, with en=1 and start=0: shadow[idx] <= sdi, idx <= idx+1 (dir=1) or idx-1 (dir=0), mod 2^IW wrap, count <= count+1.
REQ-018 In RECV, en=0 SHALL hold all state.
REQ-019 Data-bit capture SHALL stop at count==WIDTH; the completing en cycle is the WIDTH-th data bit (or the parity bit when SR_DESER_PARITY_EN is defined).
REQ-020 Completion: in the same edge, dout <= assembled word including the final bit, dout_valid <= 1, and state <= IDLE.
REQ-021 Latency: dout and dout_valid SHALL update on the clock edge that samples the final bit.
REQ-022 ack=1 with dout_valid=1 and no completion SHALL clear dout_valid on the next edge; ack with dout_valid=0 SHALL have no effect.
REQ-023 A completion while dout_valid=1 and ack=0 SHALL overwrite dout, keep dout_valid=1, and set overrun.
REQ-024 A completion coinciding with ack=1 SHALL load the new word, keep dout_valid=1, and SHALL NOT set overrun.
REQ-025 overrun SHALL clear only on reset.
REQ-026 start coinciding with the completing en SHALL take priority: no completion, and a new frame begins.

Reset
REQ-027 With reset_n=0, asynchronously: state=IDLE, idx=0, count=0, shadow=0, dout=0, dout_valid=0, busy=0, overrun=0, parity_err=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, no capture SHALL occur before the next start.

Configuration
REQ-029 Macro SR_DESER_PARITY_EN.
- Defined: a frame is WIDTH data bits followed by one even-parity bit captured on the next en cycle in RECV.
- On completion, parity_err <= (XOR of data bits) XOR (parity bit); parity_err SHALL update only on completion.
REQ-030 Macro SR_DESER_PARITY_EN not defined: a frame is WIDTH bits, and parity_err SHALL be constant 0; the port SHALL remain present.

Verification
REQ-031 WIDTH=8, start with incr=1, then 8 en cycles with sdi=1,0,1,1,0,0,1,0 -> dout=8'h4D and dout_valid=1 on the 8th en edge, busy=0 afterwards.
REQ-032 Same bits with incr=0 -> dout=8'hB2.
REQ-033 Word 8'hA5 completes with no ack, then word 8'h3C completes -> dout=8'h3C, dout_valid=1, overrun=1; ack -> dout_valid=0, overrun stays 1.
REQ-034 After 4 bits, assert start; then send 8 bits of 8'hF0 with incr=1 -> dout=8'hF0, with no trace of the aborted bits; en gaps of 3 idle cycles between bits -> same result.
REQ-035 reset_n low after 5 bits -> all outputs 0 immediately; 8 en cycles without start -> dout_valid remains 0.
REQ-036 With SR_DESER_PARITY_EN, data 8'h07 and parity bit 1 -> parity_err=0; parity bit 0 -> parity_err=1; the 8th en alone SHALL NOT assert dout_valid.
